// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg
// Shared definitions for the program-counter / fetch sequencer slice:
//   - fetch_state_e : IDLE / RUN / DONE sequencer states
//   - pc_sel_t and kPc* : PCRegSelect encodings (00 none, 01..11 link reg 1..3)
//   - PC_W_DEFAULT  : default PC and link-register width
package pc_fetch_unit_pkg;

  localparam int PC_W_DEFAULT = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } fetch_state_e;

  typedef logic [1:0] pc_sel_t;

  localparam pc_sel_t kPcNone = 2'b00;
  localparam pc_sel_t kPc1    = 2'b01;
  localparam pc_sel_t kPc2    = 2'b10;
  localparam pc_sel_t kPc3    = 2'b11;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if
// Bundle between the control decoder / host (master) and the fetch unit (slave).
//   master drives : Start, Ack, JumpEqual, JumpNotEqual, OffsetEn,
//                   PCRegSelect[1:0], ZeroIn, FlagLd
//   slave drives  : ProgCtr[PC_W-1:0], Busy, Done
//                   (+ OobErr when PC_OOB_HALT_EN is defined)
interface pc_fetch_unit_if #(
  parameter int PC_W = pc_fetch_unit_pkg::PC_W_DEFAULT
);
  logic            Start;
  logic            Ack;
  logic            JumpEqual;
  logic            JumpNotEqual;
  logic            OffsetEn;
  logic [1:0]      PCRegSelect;
  logic            ZeroIn;
  logic            FlagLd;
  logic [PC_W-1:0] ProgCtr;
  logic            Busy;
  logic            Done;
`ifdef PC_OOB_HALT_EN
  logic            OobErr;
`endif

  modport master (
    output Start, Ack, JumpEqual, JumpNotEqual, OffsetEn, PCRegSelect, ZeroIn, FlagLd,
    input  ProgCtr, Busy, Done
`ifdef PC_OOB_HALT_EN
    , input OobErr
`endif
  );

  modport slave (
    input  Start, Ack, JumpEqual, JumpNotEqual, OffsetEn, PCRegSelect, ZeroIn, FlagLd,
    output ProgCtr, Busy, Done
`ifdef PC_OOB_HALT_EN
    , output OobErr
`endif
  );

endinterface

// File: rtl/pc_fetch_unit_link_regs.sv
// pc_link_regs
// Three PC_W-bit link registers (PCreg1..3) saved by spc and read as jump targets.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear of all three registers (has priority over we)
//   we/wsel/wdata : write wdata into the register picked by wsel (kPcNone = no write)
//   rsel/rdata    : combinational read, kPcNone reads as zero
module pc_link_regs
  import pc_fetch_unit_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            we,
  input  pc_sel_t         wsel,
  input  logic [PC_W-1:0] wdata,
  input  pc_sel_t         rsel,
  output logic [PC_W-1:0] rdata
);

  logic [PC_W-1:0] link_q [1:3];
  logic [PC_W-1:0] link_d [1:3];

  always_comb begin
    link_d = link_q;
    if (clr) begin
      link_d[1] = '0;
      link_d[2] = '0;
      link_d[3] = '0;
    end else if (we) begin
      case (wsel)
        kPc1:    link_d[1] = wdata;
        kPc2:    link_d[2] = wdata;
        kPc3:    link_d[3] = wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      link_q[1] <= '0;
      link_q[2] <= '0;
      link_q[3] <= '0;
    end else begin
      link_q <= link_d;
    end
  end

  always_comb begin
    case (rsel)
      kPc1:    rdata = link_q[1];
      kPc2:    rdata = link_q[2];
      kPc3:    rdata = link_q[3];
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Program counter and fetch sequencer. Holds the ROM address, the three link
// registers, the registered equal flag, and the IDLE/RUN/DONE handshake.
//   Clk   : system clock, all state changes on the rising edge
//   Reset : asynchronous, active-high, returns everything to zero / IDLE
//   bus   : pc_fetch_unit_if.slave (decoder controls in, ProgCtr/Busy/Done out)
// Optional build macro PC_OOB_HALT_EN: running off PROG_LAST (sequentially or
// by a jump) halts into DONE with a sticky OobErr instead of wrapping.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int PC_W       = PC_W_DEFAULT,
  parameter int SPC_OFFSET = 2
`ifdef PC_OOB_HALT_EN
  , parameter int PROG_LAST = 2**PC_W - 1
`endif
) (
  input  logic Clk,
  input  logic Reset,
  pc_fetch_unit_if.slave bus
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            eq_q, eq_d;

  logic            link_clr;
  logic            link_we;
  logic [PC_W-1:0] link_wdata;
  logic [PC_W-1:0] link_rdata;
  logic            jump_taken;
  logic            save_req;
  logic            oob_hit;

  // Both jump flags together is an illegal encoding and never jumps; the
  // flag consulted is the one registered before this edge (no bypass).
  assign jump_taken = (bus.PCRegSelect != kPcNone) &&
                      ((bus.JumpEqual && !bus.JumpNotEqual && eq_q) ||
                       (bus.JumpNotEqual && !bus.JumpEqual && !eq_q));

  assign save_req = !bus.JumpEqual && !bus.JumpNotEqual &&
                    (bus.PCRegSelect != kPcNone);

`ifdef PC_OOB_HALT_EN
  localparam logic [PC_W:0] ProgLastW = (PC_W+1)'(PROG_LAST);
  logic oob_q, oob_d;

  assign oob_hit = jump_taken ? ({1'b0, link_rdata} > ProgLastW)
                              : ({1'b0, pc_q} == ProgLastW);
`else
  assign oob_hit = 1'b0;
`endif

  // Next-state logic: Start restarts from a clean slate, Ack beats everything
  // else in RUN, then a taken jump, otherwise a plain increment.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    eq_d       = eq_q;
    link_clr   = 1'b0;
    link_we    = 1'b0;
    link_wdata = bus.OffsetEn ? (pc_q + PC_W'(SPC_OFFSET)) : pc_q;
`ifdef PC_OOB_HALT_EN
    oob_d      = oob_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.Start) begin
          state_d  = ST_RUN;
          pc_d     = '0;
          eq_d     = 1'b0;
          link_clr = 1'b1;
`ifdef PC_OOB_HALT_EN
          oob_d    = 1'b0;
`endif
        end
      end
      ST_RUN: begin
        if (bus.Ack) begin
          state_d = ST_DONE;
        end else if (oob_hit) begin
          state_d = ST_DONE;
`ifdef PC_OOB_HALT_EN
          oob_d   = 1'b1;
`endif
        end else begin
          pc_d    = jump_taken ? link_rdata : (pc_q + PC_W'(1));
          link_we = save_req;
          if (bus.FlagLd) begin
            eq_d = bus.ZeroIn;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      eq_q    <= 1'b0;
`ifdef PC_OOB_HALT_EN
      oob_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      eq_q    <= eq_d;
`ifdef PC_OOB_HALT_EN
      oob_q   <= oob_d;
`endif
    end
  end

  pc_link_regs #(
    .PC_W (PC_W)
  ) u_link_regs (
    .clk   (Clk),
    .rst   (Reset),
    .clr   (link_clr),
    .we    (link_we),
    .wsel  (bus.PCRegSelect),
    .wdata (link_wdata),
    .rsel  (bus.PCRegSelect),
    .rdata (link_rdata)
  );

  assign bus.ProgCtr = pc_q;
  assign bus.Busy    = (state_q == ST_RUN);
  assign bus.Done    = (state_q == ST_DONE);
`ifdef PC_OOB_HALT_EN
  assign bus.OobErr  = oob_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
// Self-checking bench for pc_fetch_unit. Instance A (PC_W=10) walks a vector
// table covering increment, spc save with/without offset, je/jne taken and not
// taken, illegal double-jump, old-flag use, Ack/DONE freeze and restart.
// Instance B (PC_W=4) checks the 15 -> 0 wrap, or the PC_OOB_HALT_EN halt.
module tb_pc_fetch_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pc_fetch_unit_if #(.PC_W(10)) busA ();
  pc_fetch_unit_if #(.PC_W(4))  busB ();

  pc_fetch_unit #(.PC_W(10), .SPC_OFFSET(2)) dutA (
    .Clk   (clk),
    .Reset (rst),
    .bus   (busA.slave)
  );

  pc_fetch_unit #(.PC_W(4), .SPC_OFFSET(2)) dutB (
    .Clk   (clk),
    .Reset (rst),
    .bus   (busB.slave)
  );

  typedef struct {
    logic       start, ack, je, jne, off;
    logic [1:0] sel;
    logic       zero, fld;
    logic [9:0] pc;
    logic       busy, done;
  } vec_t;

  typedef struct {
    int         dut;
    logic [9:0] pc;
    logic       busy, done;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Builds one table row: inputs for a cycle, then expected outputs after its edge.
  function automatic vec_t mk(input int s, a, je, jne, off, sel, z, f, pc, bz, dn);
    vec_t v;
    v.start = s[0];  v.ack = a[0];  v.je = je[0];  v.jne = jne[0];
    v.off = off[0];  v.sel = sel[1:0];  v.zero = z[0];  v.fld = f[0];
    v.pc = pc[9:0];  v.busy = bz[0];  v.done = dn[0];
    return v;
  endfunction

  task automatic cmpVal(input string name, input logic [9:0] act, input logic [9:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int dut, input vec_t v, input string name);
    exp_t e;
    if (dut == 0) begin
      busA.Start = v.start;  busA.Ack = v.ack;  busA.JumpEqual = v.je;
      busA.JumpNotEqual = v.jne;  busA.OffsetEn = v.off;  busA.PCRegSelect = v.sel;
      busA.ZeroIn = v.zero;  busA.FlagLd = v.fld;
    end else begin
      busB.Start = v.start;  busB.Ack = v.ack;  busB.JumpEqual = v.je;
      busB.JumpNotEqual = v.jne;  busB.OffsetEn = v.off;  busB.PCRegSelect = v.sel;
      busB.ZeroIn = v.zero;  busB.FlagLd = v.fld;
    end
    e.dut = dut;  e.pc = v.pc;  e.busy = v.busy;  e.done = v.done;  e.name = name;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [9:0] pc;
    logic       b, d;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = sb.pop_front();
    if (e.dut == 0) begin
      pc = busA.ProgCtr;  b = busA.Busy;  d = busA.Done;
    end else begin
      pc = {6'b0, busB.ProgCtr};  b = busB.Busy;  d = busB.Done;
    end
    cmpVal({e.name, ".pc"},   pc,          e.pc);
    cmpVal({e.name, ".busy"}, {9'b0, b},   {9'b0, e.busy});
    cmpVal({e.name, ".done"}, {9'b0, d},   {9'b0, e.done});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //             s a je jne off sel z f  pc bz dn
    vecs.push_back(mk(0,1,1,1,1,1,1,1, 0,0,0));   // IDLE ignores everything but Start
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,1,0));   // Start -> RUN at 0
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 2,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 3,1,0));
    vecs.push_back(mk(0,0,0,0,1,1,0,0, 4,1,0));   // spc at 3 with offset: PCreg1 = 5
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 5,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 6,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 7,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,1, 8,1,0));   // flag <= 1
    vecs.push_back(mk(0,0,1,0,0,1,0,0, 5,1,0));   // je taken -> PCreg1
    vecs.push_back(mk(0,0,0,1,0,1,0,1, 6,1,0));   // jne uses old flag (1): not taken; flag <= 0
    vecs.push_back(mk(0,0,0,1,0,1,0,0, 5,1,0));   // jne now taken
    vecs.push_back(mk(0,0,1,1,0,1,0,0, 6,1,0));   // illegal both: increment
    vecs.push_back(mk(0,0,0,1,0,0,0,0, 7,1,0));   // jne with sel 00: increment
    vecs.push_back(mk(0,0,0,0,0,2,0,0, 8,1,0));   // spc no offset at 7: PCreg2 = 7
    vecs.push_back(mk(0,0,0,1,0,2,0,0, 7,1,0));   // jne -> PCreg2
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 8,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 9,1,0));
    vecs.push_back(mk(0,1,0,1,0,1,1,1, 9,0,1));   // Ack wins: DONE, PC holds
    vecs.push_back(mk(0,0,1,0,0,1,0,0, 9,0,1));
    vecs.push_back(mk(0,1,0,1,0,2,1,1, 9,0,1));
    for (int k = 0; k < 8; k++) vecs.push_back(mk(0,0,0,0,0,0,0,0, 9,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,1,0));   // restart from DONE
    vecs.push_back(mk(0,0,0,1,0,1,0,0, 0,1,0));   // jne -> cleared PCreg1 = 0
    vecs.push_back(mk(0,0,1,0,0,1,0,0, 1,1,0));   // je with cleared flag: not taken
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 2,1,0));   // Start in RUN ignored
    vecs.push_back(mk(0,0,0,0,0,3,0,0, 3,1,0));   // spc at 2: PCreg3 = 2
    vecs.push_back(mk(0,0,0,0,0,0,1,1, 4,1,0));   // flag <= 1
    vecs.push_back(mk(0,0,1,0,0,3,0,0, 2,1,0));   // je -> PCreg3
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 3,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 4,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 5,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 6,1,0));

    rst = 1'b1;
    applyStimulus(0, mk(0,0,0,0,0,0,0,0, 0,0,0), "resetA");
    applyStimulus(1, mk(0,0,0,0,0,0,0,0, 0,0,0), "resetB");
    #12;
    checkOutput();
    checkOutput();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(0, vecs[i], $sformatf("vec%0d", i));
      tick();
      checkOutput();
    end

    // Asynchronous reset between edges while running at PC 6.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    cmpVal("asyncReset.pc",   busA.ProgCtr,        10'd0);
    cmpVal("asyncReset.busy", {9'b0, busA.Busy},   10'd0);
    cmpVal("asyncReset.done", {9'b0, busA.Done},   10'd0);
    @(negedge clk);
    rst = 1'b0;

    // Narrow instance: run off the top of the 16-entry address space.
    @(negedge clk);
    applyStimulus(1, mk(1,0,0,0,0,0,0,0, 0,1,0), "wrapStart");
    tick();
    checkOutput();
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      applyStimulus(1, mk(0,0,0,0,0,0,0,0, k,1,0), $sformatf("wrap%0d", k));
      tick();
      checkOutput();
    end
    @(negedge clk);
`ifdef PC_OOB_HALT_EN
    applyStimulus(1, mk(0,0,0,0,0,0,0,0, 15,0,1), "oobHalt");
    tick();
    checkOutput();
    cmpVal("oobHalt.err", {9'b0, busB.OobErr}, 10'd1);
    @(negedge clk);
    applyStimulus(1, mk(0,0,0,0,0,0,0,0, 15,0,1), "oobHold");
    tick();
    checkOutput();
`else
    applyStimulus(1, mk(0,0,0,0,0,0,0,0, 0,1,0), "wrapTo0");
    tick();
    checkOutput();
    @(negedge clk);
    applyStimulus(1, mk(0,0,0,0,0,0,0,0, 1,1,0), "wrapTo1");
    tick();
    checkOutput();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
